// File: rtl/reg_writeback_sequencer_if.sv
// Bundle between the execute/memory stages, the write-back sequencer and the
// register bank write port. The sequencer drives the bank side and the ready signals.
interface reg_writeback_sequencer_if #(
    parameter int DIR     = 4,
    parameter int BUS     = 2 ** (DIR + 1),
    parameter int REG_NUM = 2 ** DIR
);
    logic               alu_valid;
    logic               alu_ready;
    logic [DIR-1:0]     alu_rd;
    logic [BUS-1:0]     alu_data;

    logic               ldm_valid;
    logic               ldm_ready;
    logic [REG_NUM-1:0] ldm_mask;

    logic               mem_valid;
    logic               mem_ready;
    logic [BUS-1:0]     mem_data;

    logic               pc_step;
    logic [BUS-1:0]     pc_next;

    logic [DIR-1:0]     address;
    logic [BUS-1:0]     write_data;
    logic               WE;
    logic [BUS-1:0]     pc_in;
    logic               flush;
    logic               ldm_done;
    logic               busy;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ldm_valid, ldm_mask,
        input  mem_valid, mem_data,
        input  pc_step, pc_next,
        output alu_ready, ldm_ready, mem_ready,
        output address, write_data, WE, pc_in, flush, ldm_done, busy
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ldm_valid, ldm_mask,
        output mem_valid, mem_data,
        output pc_step, pc_next,
        input  alu_ready, ldm_ready, mem_ready,
        input  address, write_data, WE, pc_in, flush, ldm_done, busy
    );
endinterface

// File: rtl/reg_writeback_sequencer.sv
// Serialises single ALU results and load-multiple bursts onto the register bank
// write port; writes to r15 become PC redirects with a one-cycle flush pulse.
module reg_writeback_sequencer #(
    parameter int DIR     = 4,
    parameter int BUS     = 2 ** (DIR + 1),
    parameter int REG_NUM = 2 ** DIR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    reg_writeback_sequencer_if.slave   wb
);
    typedef enum logic {
        IDLE = 1'b0,
        LDM  = 1'b1
    } state_t;

    localparam logic [DIR-1:0]     PC_REG   = {DIR{1'b1}};
    localparam logic [REG_NUM-1:0] MASK_ONE = {{(REG_NUM-1){1'b0}}, 1'b1};

    state_t             state_q;
    logic [REG_NUM-1:0] mask_q;
    logic [DIR-1:0]     address_q;
    logic [BUS-1:0]     write_data_q;
    logic [BUS-1:0]     pc_in_q;
    logic               we_q;
    logic               flush_q;
    logic               ldm_done_q;

    logic               alu_accept;
    logic               ldm_accept;
    logic               mem_accept;
    logic [DIR-1:0]     ldm_target;
    logic [REG_NUM-1:0] mask_rest;
    logic               alu_pc_wr;
    logic               ldm_pc_wr;
    logic               pc_wr;
    logic [BUS-1:0]     pc_wr_data;

    // Ready signals are forced low while reset is held so nothing is accepted.
    assign wb.alu_ready = rst_n && (state_q == IDLE);
    assign wb.ldm_ready = rst_n && (state_q == IDLE) && !wb.alu_valid;
    assign wb.mem_ready = rst_n && (state_q == LDM);

    assign alu_accept = wb.alu_valid && wb.alu_ready;
    assign ldm_accept = wb.ldm_valid && wb.ldm_ready;
    assign mem_accept = wb.mem_valid && wb.mem_ready;

    // Lowest set bit of the remaining list gives ascending load order.
    always_comb begin
        ldm_target = '0;
        for (int i = REG_NUM - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                ldm_target = i[DIR-1:0];
            end
        end
    end

    assign mask_rest  = mask_q & (mask_q - MASK_ONE);
    assign alu_pc_wr  = alu_accept && (wb.alu_rd == PC_REG);
    assign ldm_pc_wr  = mem_accept && (ldm_target == PC_REG);
    assign pc_wr      = alu_pc_wr || ldm_pc_wr;
    assign pc_wr_data = alu_pc_wr ? wb.alu_data : wb.mem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            address_q    <= '0;
            write_data_q <= '0;
            pc_in_q      <= '0;
            we_q         <= 1'b0;
            flush_q      <= 1'b0;
            ldm_done_q   <= 1'b0;
        end else begin
            we_q       <= 1'b0;
            flush_q    <= 1'b0;
            ldm_done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (alu_accept) begin
                        if (!alu_pc_wr) begin
                            we_q         <= 1'b1;
                            address_q    <= wb.alu_rd;
                            write_data_q <= wb.alu_data;
                        end
                    end else if (ldm_accept) begin
                        if (wb.ldm_mask == '0) begin
                            ldm_done_q <= 1'b1;
                        end else begin
                            mask_q  <= wb.ldm_mask;
                            state_q <= LDM;
                        end
                    end
                end
                LDM: begin
                    if (mem_accept) begin
                        if (!ldm_pc_wr) begin
                            we_q         <= 1'b1;
                            address_q    <= ldm_target;
                            write_data_q <= wb.mem_data;
                        end
                        mask_q <= mask_rest;
                        if (mask_rest == '0) begin
                            ldm_done_q <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    mask_q  <= '0;
                end
            endcase

            // A redirect through r15 overrides sequential PC advance.
            if (pc_wr) begin
                pc_in_q <= pc_wr_data;
                flush_q <= 1'b1;
            end else if (wb.pc_step) begin
                pc_in_q <= wb.pc_next;
            end
        end
    end

    assign wb.address    = address_q;
    assign wb.write_data = write_data_q;
    assign wb.WE         = we_q;
    assign wb.pc_in      = pc_in_q;
    assign wb.flush      = flush_q;
    assign wb.ldm_done   = ldm_done_q;
    assign wb.busy       = (state_q == LDM);
endmodule
